// File: rtl/data_router_sender.sv
// Streams upstream feature words into a banked input buffer, tile by tile,
// generating bank/row/column write addresses and handshaking tile release with the consumer.
module data_router_sender #(
  parameter int unsigned DW     = 32,
  parameter int unsigned POY    = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned BUFW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   num_tiles,
  input  logic          buf_release,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wvalid,
  output logic [DW-1:0] wdata,
  output logic [7:0]    wbank,
  output logic [7:0]    wrow,
  output logic [27:0]   wcol,
  output logic          busy,
  output logic          done
);

  localparam int unsigned BUFH = 2 * STRIDE;

  typedef enum logic [1:0] {StIdle, StFill, StWaitRel, StDone} state_e;

  state_e        state_q, state_d;
  logic [27:0]   col_q, col_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    bank_q, bank_d;
  logic [15:0]   tile_q, tile_d;
  logic [15:0]   ntiles_q, ntiles_d;
  logic          wvalid_q, wvalid_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wbank_q, wbank_d;
  logic [7:0]    wrow_q, wrow_d;
  logic [27:0]   wcol_q, wcol_d;
  logic          hs;

  assign hs = (state_q == StFill) && in_valid;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    bank_d   = bank_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    wvalid_d = 1'b0;
    wdata_d  = wdata_q;
    wbank_d  = wbank_q;
    wrow_d   = wrow_q;
    wcol_d   = wcol_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ntiles_d = num_tiles;
          tile_d   = '0;
          col_d    = '0;
          row_d    = '0;
          bank_d   = '0;
          state_d  = (num_tiles == 16'd0) ? StDone : StFill;
        end
      end
      StFill: begin
        if (hs) begin
          // Write is registered: address is the counter value at the handshake.
          wvalid_d = 1'b1;
          wdata_d  = in_data;
          wbank_d  = bank_q;
          wrow_d   = row_q;
          wcol_d   = col_q;
          if (col_q == 28'(BUFW - 1)) begin
            col_d = '0;
            if (row_q == 8'(BUFH - 1)) begin
              row_d = '0;
              if (bank_q == 8'(POY - 1)) begin
                bank_d = '0;
                if (tile_q == ntiles_q - 16'd1) begin
                  state_d = StDone;
                end else begin
                  tile_d  = tile_q + 16'd1;
                  state_d = StWaitRel;
                end
              end else begin
                bank_d = bank_q + 8'd1;
              end
            end else begin
              row_d = row_q + 8'd1;
            end
          end else begin
            col_d = col_q + 28'd1;
          end
        end
      end
      StWaitRel: begin
        if (buf_release) state_d = StFill;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      bank_q   <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wbank_q  <= '0;
      wrow_q   <= '0;
      wcol_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bank_q   <= bank_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wbank_q  <= wbank_d;
      wrow_q   <= wrow_d;
      wcol_q   <= wcol_d;
    end
  end

  assign in_ready = (state_q == StFill);
  assign busy     = (state_q == StFill) || (state_q == StWaitRel);
  assign done     = (state_q == StDone);
  assign wvalid   = wvalid_q;
  assign wdata    = wdata_q;
  assign wbank    = wbank_q;
  assign wrow     = wrow_q;
  assign wcol     = wcol_q;

endmodule
